// File: rtl/dcache_ctrl_pkg.sv
// Shared widths, address field helpers and miss-FSM encoding for the data cache.
package dcache_ctrl_pkg;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int SB_WIDTH      = 64;
    localparam int DC_NLINES     = 4;
    localparam int DC_LINE_WORDS = 4;

    localparam int LINE_WIDTH = DATA_WIDTH * DC_LINE_WORDS;
    localparam int OFF_WIDTH  = $clog2(DC_LINE_WORDS);
    localparam int IDX_WIDTH  = $clog2(DC_NLINES);
    localparam int BYTE_OFF   = $clog2(DATA_WIDTH / 8);
    localparam int LINE_LSB   = BYTE_OFF + OFF_WIDTH;
    localparam int TAG_LSB    = LINE_LSB + IDX_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - TAG_LSB;
    localparam int LADDR_WIDTH = ADDR_WIDTH - LINE_LSB;

    typedef logic [DC_LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } dc_state_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:TAG_LSB];
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[TAG_LSB-1:LINE_LSB];
    endfunction

    function automatic logic [OFF_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return a[LINE_LSB-1:BYTE_OFF];
    endfunction
endpackage

// File: rtl/dcache_ctrl_array.sv
// Tag/valid/dirty/data storage: asynchronous read, one word write and one line write port.
module dcache_ctrl_array
    import dcache_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_WIDTH-1:0]  rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_WIDTH-1:0]  rd_tag,
    output line_t                 rd_line,
    input  logic                  word_we,
    input  logic [IDX_WIDTH-1:0]  word_index,
    input  logic [OFF_WIDTH-1:0]  word_offset,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  line_we,
    input  logic [IDX_WIDTH-1:0]  line_index,
    input  logic [TAG_WIDTH-1:0]  line_tag,
    input  line_t                 line_data,
    input  logic                  clr_dirty,
    input  logic [IDX_WIDTH-1:0]  clr_index
);
    logic                 valid_vec [DC_NLINES];
    logic                 dirty_vec [DC_NLINES];
    logic [TAG_WIDTH-1:0] tag_vec   [DC_NLINES];
    line_t                data_vec  [DC_NLINES];

    genvar gi;
    generate
        for (gi = 0; gi < DC_NLINES; gi++) begin : g_line
            logic                 valid_reg;
            logic                 dirty_reg;
            logic [TAG_WIDTH-1:0] tag_reg;
            line_t                data_reg;
            logic                 sel_word;
            logic                 sel_line;
            logic                 sel_clr;

            assign sel_word = word_we   && (word_index == IDX_WIDTH'(gi));
            assign sel_line = line_we   && (line_index == IDX_WIDTH'(gi));
            assign sel_clr  = clr_dirty && (clr_index  == IDX_WIDTH'(gi));

            // Only state bits are reset; stale data is masked by valid.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (sel_line) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                end else if (sel_word) begin
                    dirty_reg <= 1'b1;
                end else if (sel_clr) begin
                    dirty_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (sel_line) begin
                    tag_reg  <= line_tag;
                    data_reg <= line_data;
                end else if (sel_word) begin
                    data_reg[word_offset] <= word_data;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
            assign tag_vec[gi]   = tag_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign rd_valid = valid_vec[rd_index];
    assign rd_dirty = dirty_vec[rd_index];
    assign rd_tag   = tag_vec[rd_index];
    assign rd_line  = data_vec[rd_index];
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: load/drain arbitration, miss FSM, memory port registers.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_load,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic                  sb_fwd_hit,
    input  logic                  sb_valid,
    input  logic [SB_WIDTH-1:0]   sb_entry,
    output logic                  cache_hit,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  dc_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);
    dc_state_t               state_reg;
    logic [LADDR_WIDTH-1:0]  miss_line_reg;
    logic                    miss_load_reg;

    logic [ADDR_WIDTH-1:0]   sb_addr;
    logic [DATA_WIDTH-1:0]   sb_data;
    logic [ADDR_WIDTH-1:0]   lookup_addr;
    logic                    load_req, in_idle, lookup_hit;
    logic                    load_hit, load_miss, drain_try, drain_hit, drain_miss;
    logic                    rd_valid, rd_dirty;
    logic [TAG_WIDTH-1:0]    rd_tag;
    line_t                   rd_line;
    logic                    unused_bits;

    assign sb_addr  = sb_entry[SB_WIDTH-1:DATA_WIDTH];
    assign sb_data  = sb_entry[DATA_WIDTH-1:0];
    assign load_req = is_load & ~sb_fwd_hit;
    assign in_idle  = (state_reg == ST_IDLE);

    // A single lookup port: an unforwarded load owns it, otherwise the drain does.
    assign lookup_addr = load_req ? ld_addr : sb_addr;
    assign lookup_hit  = rd_valid && (rd_tag == addr_tag(lookup_addr));

    assign load_hit   = in_idle & load_req & lookup_hit;
    assign load_miss  = in_idle & load_req & ~lookup_hit;
    assign drain_try  = in_idle & ~load_req & sb_valid;
    assign drain_hit  = drain_try & lookup_hit;
    assign drain_miss = drain_try & ~lookup_hit;

    assign cache_hit = drain_hit;
    assign ld_data   = load_hit ? rd_line[addr_offset(ld_addr)] : '0;
    assign dc_stall  = load_miss | (~in_idle & (miss_load_reg | load_req));
    assign unused_bits = ^lookup_addr[BYTE_OFF-1:0];

    dcache_ctrl_array u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (addr_index(lookup_addr)),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .word_we     (drain_hit),
        .word_index  (addr_index(sb_addr)),
        .word_offset (addr_offset(sb_addr)),
        .word_data   (sb_data),
        .line_we     ((state_reg == ST_REFILL) & mem_ready),
        .line_index  (miss_line_reg[IDX_WIDTH-1:0]),
        .line_tag    (miss_line_reg[LADDR_WIDTH-1:IDX_WIDTH]),
        .line_data   (mem_rdata),
        .clr_dirty   ((state_reg == ST_WRITEBACK) & mem_ready),
        .clr_index   (miss_line_reg[IDX_WIDTH-1:0])
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            miss_line_reg <= '0;
            miss_load_reg <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_miss | drain_miss) begin
                        miss_line_reg <= lookup_addr[ADDR_WIDTH-1:LINE_LSB];
                        miss_load_reg <= load_miss;
                        mem_req       <= 1'b1;
                        if (rd_valid & rd_dirty) begin
                            state_reg <= ST_WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, addr_index(lookup_addr), {LINE_LSB{1'b0}}};
                            mem_wdata <= rd_line;
                        end else begin
                            state_reg <= ST_REFILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {lookup_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        state_reg <= ST_REFILL;
                        mem_we    <= 1'b0;
                        mem_addr  <= {miss_line_reg, {LINE_LSB{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (mem_ready) begin
                        state_reg     <= ST_IDLE;
                        mem_req       <= 1'b0;
                        miss_load_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a latency-L memory responder and an expected-request queue.
module tb_dcache_ctrl;
    logic         clk;
    logic         reset;
    logic         is_load;
    logic [31:0]  ld_addr;
    logic         sb_fwd_hit;
    logic         sb_valid;
    logic [63:0]  sb_entry;
    logic         cache_hit;
    logic [31:0]  ld_data;
    logic         dc_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } mem_exp_t;

    mem_exp_t     exp_q[$];
    logic [127:0] mem_model [logic [31:0]];
    int           errors = 0;
    int           checks = 0;
    int           mem_lat = 3;
    bit           mem_auto = 1'b1;

    dcache_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .is_load    (is_load),
        .ld_addr    (ld_addr),
        .sb_fwd_hit (sb_fwd_hit),
        .sb_valid   (sb_valid),
        .sb_entry   (sb_entry),
        .cache_hit  (cache_hit),
        .ld_data    (ld_data),
        .dc_stall   (dc_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic wait_no_stall(output int n);
        n = 0;
        settle();
        while (dc_stall === 1'b1 && n < 100) begin
            n++;
            tick();
            settle();
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic we, input logic [127:0] wd);
        mem_exp_t e;
        e.addr  = a;
        e.we    = we;
        e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Memory responder: mem_ready on the (L+1)th cycle of a held request.
    initial begin
        int cnt;
        mem_exp_t e;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            if (mem_auto) begin
                mem_ready = 1'b0;
                if (mem_req !== 1'b1) begin
                    cnt = 0;
                end else begin
                    cnt++;
                    if (cnt == mem_lat + 1) begin
                        cnt = 0;
                        mem_ready = 1'b1;
                        chk("mem_req_expected", 128'(exp_q.size() > 0), 128'(1));
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            $display("mem txn addr=%0h we=%0b wdata=%0h", mem_addr, mem_we, mem_wdata);
                            chk("mem_addr", mem_addr, e.addr);
                            chk("mem_we", mem_we, e.we);
                            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        end
                        if (mem_we) mem_model[mem_addr] = mem_wdata;
                        else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit stall_seen;
        reset = 1'b0; is_load = 1'b0; ld_addr = '0; sb_fwd_hit = 1'b0;
        sb_valid = 1'b0; sb_entry = '0;
        mem_model[32'h40] = {32'h44, 32'h33, 32'h22, 32'h11};
        mem_model[32'h80] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        mem_model[32'hB0] = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

        tick(); tick(); settle();
        chk("rst_cache_hit", cache_hit, 0);
        chk("rst_dc_stall", dc_stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ld_data", ld_data, 0);
        tick(); reset = 1'b1; tick();

        // Cold clean miss on 0x40, then retry hit and neighbour hit.
        push_exp(32'h40, 1'b0, '0);
        is_load = 1'b1; ld_addr = 32'h40;
        wait_no_stall(n);
        $display("cold load 0x40 stall=%0d data=%0h", n, ld_data);
        chk("cold_stall_cycles", n, 5);
        chk("cold_ld_data", ld_data, 32'h11);
        tick();
        ld_addr = 32'h44; settle();
        chk("hit44_stall", dc_stall, 0);
        chk("hit44_data", ld_data, 32'h22);
        tick();

        // Drain hit on resident line.
        is_load = 1'b0; sb_valid = 1'b1; sb_entry = {32'h40, 32'hDDDD}; settle();
        $display("drain 0x40 cache_hit=%0b", cache_hit);
        chk("drain_hit", cache_hit, 1);
        tick();
        sb_valid = 1'b0; is_load = 1'b1; ld_addr = 32'h40; settle();
        chk("drain_readback", ld_data, 32'hDDDD);
        tick();

        // Dirty conflict miss: write-back 0x40 then refill 0x80.
        push_exp(32'h40, 1'b1, {32'h44, 32'h33, 32'h22, 32'hDDDD});
        push_exp(32'h80, 1'b0, '0);
        ld_addr = 32'h80;
        wait_no_stall(n);
        $display("dirty load 0x80 stall=%0d data=%0h", n, ld_data);
        chk("dirty_stall_cycles", n, 9);
        chk("dirty_ld_data", ld_data, 32'hA0);
        chk("wb_model_0x40", mem_model[32'h40], {32'h44, 32'h33, 32'h22, 32'hDDDD});
        tick();

        // Unforwarded load beats drain; drain succeeds the following cycle.
        ld_addr = 32'h84; sb_valid = 1'b1; sb_entry = {32'h88, 32'h1234}; settle();
        $display("load+drain cache_hit=%0b data=%0h", cache_hit, ld_data);
        chk("prio_drain_blocked", cache_hit, 0);
        chk("prio_ld_data", ld_data, 32'hA1);
        chk("prio_no_stall", dc_stall, 0);
        tick();
        is_load = 1'b0; settle();
        chk("prio_drain_next", cache_hit, 1);
        tick();

        // Forwarded load leaves the cache free for the drain, even on a would-be miss.
        is_load = 1'b1; sb_fwd_hit = 1'b1; ld_addr = 32'h200;
        sb_entry = {32'h8C, 32'h5678}; settle();
        $display("fwd load+drain cache_hit=%0b stall=%0b", cache_hit, dc_stall);
        chk("fwd_drain_hit", cache_hit, 1);
        chk("fwd_no_stall", dc_stall, 0);
        tick();
        sb_fwd_hit = 1'b0; sb_valid = 1'b0; ld_addr = 32'h88; settle();
        chk("drain88_readback", ld_data, 32'h1234);
        tick();
        ld_addr = 32'h8C; settle();
        chk("drain8c_readback", ld_data, 32'h5678);
        tick();

        // Drain miss: refill without stalling, then a single cache_hit.
        is_load = 1'b0; push_exp(32'hB0, 1'b0, '0);
        sb_valid = 1'b1; sb_entry = {32'hBB, 32'hFFFF}; settle();
        chk("drain_miss_first", cache_hit, 0);
        n = 0; stall_seen = 1'b0;
        while (cache_hit !== 1'b1 && n < 50) begin
            if (dc_stall !== 1'b0) stall_seen = 1'b1;
            n++;
            tick(); settle();
        end
        $display("drain miss 0xBB cycles_to_hit=%0d stall_seen=%0b", n, stall_seen);
        chk("drain_miss_cycles", n, 5);
        chk("drain_miss_no_stall", stall_seen, 0);
        tick();
        sb_valid = 1'b0; settle();
        chk("drain_miss_single_pulse", cache_hit, 0);
        tick();
        is_load = 1'b1; ld_addr = 32'hB8; settle();
        chk("drainBB_readback", ld_data, 32'hFFFF);
        chk("mem_queue_drained", exp_q.size(), 0);
        mem_auto = 1'b0;
        tick();

        // Reset asserted during REFILL; late mem_ready must be ignored.
        ld_addr = 32'h50; settle();
        chk("miss50_stall", dc_stall, 1);
        tick();
        chk("miss50_mem_req", mem_req, 1);
        chk("miss50_mem_addr", mem_addr, 32'h50);
        tick();
        is_load = 1'b0; reset = 1'b0; #1;
        $display("reset mid-refill mem_req=%0b", mem_req);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b1; mem_ready = 1'b1; settle();
        chk("late_ready_no_req", mem_req, 0);
        tick();
        mem_ready = 1'b0; is_load = 1'b1; ld_addr = 32'hB8; settle();
        $display("post-reset load 0xB8 stall=%0b", dc_stall);
        chk("post_reset_miss", dc_stall, 1);
        tick();
        is_load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the store buffer and beside the load path of the monocycle core. It serves pipeline loads, absorbs store-buffer drain writes (returning `cache_hit` so the buffer can retire its oldest entry), and runs a miss FSM that writes back dirty victims and refills lines from a variable-latency memory port. The core stalls only on load misses not forwarded by the store buffer.

## Interface
- `ADDR_WIDTH` (define), default 32: byte address width.
- `DATA_WIDTH` (define), default 32: word width.
- `SB_WIDTH` (define), default 64: store-buffer entry, `{addr[63:32], data[31:0]}`.
- `DC_NLINES`, default 4: lines; index = addr[5:4].
- `DC_LINE_WORDS`, default 4: words per line (128-bit line); word offset = addr[3:2]; tag = addr[31:6].
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `is_load`  in  1  pipeline load request this cycle.
- `ld_addr`  in  `ADDR_WIDTH`  load address (word-aligned).
- `sb_fwd_hit`  in  1  store buffer forwarded this load (`SB_hit`); cache must not miss-handle it.
- `sb_valid`  in  1  store buffer presenting a drain entry (`sending_data_to_cache`).
- `sb_entry`  in  `SB_WIDTH`  drain entry (`data_to_cache`).
- `cache_hit`  out  1  drain write performed this cycle; SB pops entry on this edge.
- `ld_data`  out  `DATA_WIDTH`  load result, valid when `is_load & ~dc_stall`.
- `dc_stall`  out  1  freeze pipeline.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  1 = line write-back, 0 = line read.
- `mem_addr`  out  `ADDR_WIDTH`  line-aligned address (low 4 bits 0).
- `mem_wdata`  out  128  victim line.
- `mem_rdata`  in  128  refill line, valid with `mem_ready`.
- `mem_ready`  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, WRITEBACK, REFILL. Reset: state IDLE; all valid/dirty bits 0; `cache_hit`, `dc_stall`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `ld_data` = 0.
- IDLE, load (`is_load & ~sb_fwd_hit`): tag match & valid -> `ld_data` = word, combinational, no stall. Miss -> `dc_stall`=1, capture miss address; go WRITEBACK if victim valid & dirty, else REFILL.
- IDLE, drain (`sb_valid`, no unforwarded load this cycle): hit -> write word, set dirty, `cache_hit`=1 same cycle. Miss -> `cache_hit`=0, start miss for drain address (no stall).
- Load has priority: `is_load & ~sb_fwd_hit & sb_valid` -> drain not serviced, `cache_hit`=0. Forwarded load (`sb_fwd_hit`=1) leaves cache free for the drain.
- WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, 4'b0}, `mem_wdata` = victim line. On `mem_ready`: clear dirty, go REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr` = miss line. On `mem_ready`: install line, valid=1, dirty=0, tag updated, go IDLE. Requester retries in IDLE and hits.
- During WRITEBACK/REFILL: `cache_hit`=0, drains held; `dc_stall`=1 iff the miss is a load miss or a new load arrives.
- Index wrap: address beyond 4 lines aliases by index; conflicting tags evict.
- Reset mid-miss: immediate return to IDLE, `mem_req` drops, lines invalidated, pending `mem_ready` ignored, dirty data discarded.

## Timing
- Load hit / drain hit: 0 extra cycles; `cache_hit` combinational from `sb_valid` and lookup.
- Clean miss: cycle 0 detect; `mem_req` from cycle 1; `mem_ready` at cycle 1+L; hit on next cycle. Stall = L+2 cycles.
- Dirty miss: adds write-back latency plus 1 transition cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` registered and stable while `mem_req`=1.
- `mem_ready` with `mem_req`=0 is ignored.

## Structure
- Shared defines header `dcache_defs.v`: `DC_NLINES`, `DC_LINE_WORDS`, field slice macros (tag/index/offset), state encodings; reuse `ADDR_WIDTH`/`DATA_WIDTH`/`SB_WIDTH` from the store-buffer defines.
- Sub-module `dcache_array`: tag/valid/dirty/data storage, async read, one word write port plus one full-line write port.
- `dcache_ctrl`: FSM, priority arbitration, memory port registers.

## Test plan
- Cold load 0x40 after reset, memory returns line {0x44,0x33,0x22,0x11} after L=3 -> `dc_stall` 5 cycles, `mem_addr`=0x40, `ld_data`=0x11, then load 0x44 hits with 0x22 without stall.
- Drain {0x40, 0xDDDD} on resident line -> `cache_hit`=1 same cycle, later load 0x40 returns 0xDDDD.
- Load 0x80 (index 0, dirty victim 0x40) -> WRITEBACK with `mem_addr`=0x40, `mem_wdata` word0=0xDDDD, then REFILL 0x80.
- Simultaneous unforwarded load hit and drain -> `cache_hit`=0 that cycle, 1 next cycle; with `sb_fwd_hit`=1 drain succeeds same cycle.
- Drain miss {0xBB, 0xFFFF} -> `cache_hit`=0, refill of 0xB0, `dc_stall` stays 0, `cache_hit` pulses once after install.
- Deassert `reset` during REFILL -> `mem_req`=0 immediately, late `mem_ready` ignored, load of prior line misses.
